slice_add_ctrl: RTL and testbench

SLICE_ADD_CTRL -- requirements
Module: slice_add_ctrl

---
 rtl/slice_add_ctrl_pkg.sv | 13 +
 rtl/slice_add_ctrl_if.sv | 26 ++
 rtl/carry_lookahead_4bit.sv | 26 ++
 rtl/slice_add_ctrl.sv | 107 ++++++++++
 tb/tb_slice_add_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/slice_add_ctrl_pkg.sv
// Shared definitions for the slice-serial adder controller.
// Holds the FSM state encoding and the width of one arithmetic slice.
package slice_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slice_add_ctrl_if.sv
// Operand/result bundle between a requester and slice_add_ctrl.
// The master raises start with operands; the slave reports busy, the done pulse and the result.
interface slice_add_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/carry_lookahead_4bit.sv
// 4-bit carry-lookahead adder slice: purely combinational, zero latency, no handshake.
// All carries are flattened sums of generate/propagate terms, so there is no ripple chain.
module carry_lookahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s  = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/slice_add_ctrl.sv
// Slice-serial W-bit add/subtract reusing one 4-bit CLA slice; done pulses SLICES+1 cycles after accept.
// start is accepted only in IDLE and is dropped (never queued) while busy.
module slice_add_ctrl
  import slice_add_ctrl_pkg::*;
#(
  parameter int SLICES = 4
) (
  input logic              clk,
  input logic              rst_n,
  slice_add_ctrl_if.slave  bus
);

  localparam int W  = SLICE_W * SLICES;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t               state;
  state_t               state_nxt;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic [W-1:0]         work;
  logic [W-1:0]         work_nxt;
  logic [W-1:0]         sum_q;
  logic                 cout_q;
  logic                 ovf_q;
  logic [SLICE_W-1:0]   a_nib;
  logic [SLICE_W-1:0]   b_nib;
  logic [SLICE_W-1:0]   slice_s;
  logic                 slice_co;
  logic                 last;

  assign last  = (idx == IW'(SLICES - 1));
  assign a_nib = a_q[SLICE_W*idx +: SLICE_W];
  assign b_nib = b_q[SLICE_W*idx +: SLICE_W];

  carry_lookahead_4bit u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_comb begin
    work_nxt = work;
    work_nxt[SLICE_W*idx +: SLICE_W] = slice_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded in at accept time: B is inverted and the carry forced to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      work   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b ^ {W{bus.sub}};
            carry <= bus.sub ? 1'b1 : bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= slice_co;
          idx   <= idx + 1'b1;
          if (last) begin
            sum_q  <= work_nxt;
            cout_q <= slice_co;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (work_nxt[W-1] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_slice_add_ctrl.sv
// Directed bench for slice_add_ctrl: vector table plus back-to-back and mid-run reset sequences.
module tb_slice_add_ctrl;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] prev_sum;
  vec_t vecs[8];

  slice_add_ctrl_if #(.W(16)) bus ();

  slice_add_ctrl #(.SLICES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    bus.a     = v.a;
    bus.b     = v.b;
    bus.cin   = v.cin;
    bus.sub   = v.sub;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_hold_sum"}, 32'(bus.sum), 32'(prev_sum));
    check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_sum"}, 32'(bus.sum), 32'(v.exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(v.exp_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    prev_sum = v.exp_sum;
  endtask

  initial begin
    bit saw_done;
    checks = 0;
    errors = 0;
    prev_sum = 16'h0000;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0};
    vecs[6] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("v%0d", i));

    // start held high: accept, 4 RUN cycles, DONE, IDLE, re-accept -> period 6
    @(negedge clk);
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check($sformatf("b2b_busy%0d", n), 32'(bus.busy), 32'((n % 6) != 0));
      check($sformatf("b2b_done%0d", n), 32'(bus.done), 32'((n % 6) == 5));
      if ((n % 6) == 5) check($sformatf("b2b_sum%0d", n), 32'(bus.sum), 32'h0003);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_settle_busy", 32'(bus.busy), 32'd0);

    // reset while idx=2, with start asserted alongside it
    @(negedge clk);
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    saw_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    prev_sum = 16'h0000;
    run_op(vecs[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
